sdpb_access_arbiter: RTL

- Shares one 32x32 simple-dual-port block RAM (port A write, port B read) between two write requesters and two read requesters, e.g. MCU bus and line-fetch engine.
- Round-robin arbitration runs independently per port; RAM commands are registered.
- Per-requester read-valid strobes are returned after the RAM latency.
- Resolves same-cycle write/read address collisions.

---
 rtl/sdpb_arb_pkg.sv | 21 ++
 rtl/sdpb_access_arbiter_rr_arb2.sv | 36 +++
 rtl/sdpb_access_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sdpb_arb_pkg.sv
// Shared types and default sizes for the SDPB access arbiter.
package sdpb_arb_pkg;

   localparam int ADDR_W_DEF   = 5;
   localparam int DATA_W_DEF   = 32;
   localparam int READ_LAT_DEF = 1;

   // Identifies one of the two requesters on a port
   typedef logic req_id_t;

   // One slot of the read-return pipeline; fwd_data is sized to the default
   // data width, so instances with DATA_W above DATA_W_DEF lose upper
   // forwarded bits
   typedef struct packed {
      logic                    valid;
      req_id_t                 id;
      logic                    fwd;
      logic [DATA_W_DEF-1:0]   fwd_data;
   } ret_entry_t;

endpackage

// File: rtl/sdpb_access_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a last-granted pointer.
// cand is the winner ignoring hold; gnt is the real grant. The pointer only
// moves on a real grant, so a held-off winner keeps its priority.
module rr_arb2
   import sdpb_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       hold,
   output logic [1:0] cand,
   output logic [1:0] gnt
);

   req_id_t last;

   // Pick the requester that was not granted last when both are asking
   always_comb begin
      cand = req;
      if (req == 2'b11) begin
         cand = last ? 2'b01 : 2'b10;
      end
   end

   assign gnt = hold ? 2'b00 : cand;

   // Remember who won; after reset requester 1 counts as last winner
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/sdpb_access_arbiter.sv
// Arbitrates two writers and two readers onto one simple-dual-port RAM.
// Optional macro SDPB_ARB_FORWARD_EN: when defined, a read that collides with
// a same-cycle write is granted and returns the write data through the return
// pipeline; when undefined, the colliding read is held off for one cycle.
module sdpb_access_arbiter
   import sdpb_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int READ_LAT = READ_LAT_DEF
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        wr_req,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        wr_gnt,
   input  logic [1:0]        rd_req,
   input  logic [ADDR_W-1:0] rd_addr0,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [1:0]        rd_gnt,
   output logic [1:0]        rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              ram_cea,
   output logic [ADDR_W-1:0] ram_ada,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_ceb,
   output logic [ADDR_W-1:0] ram_adb,
   output logic              ram_oce,
   input  logic [DATA_W-1:0] ram_dout
);

   logic [1:0]        wr_cand;
   logic [1:0]        rd_cand;
   logic [ADDR_W-1:0] wr_addr_sel;
   logic [DATA_W-1:0] wr_data_sel;
   logic [ADDR_W-1:0] rd_addr_sel;
   logic              collision;
   logic              rd_hold;
   logic              fwd_now;
   ret_entry_t        pipe [READ_LAT+1];

   rr_arb2 u_wr_arb (
      .clk   (clk),
      .reset (reset),
      .req   (wr_req),
      .hold  (1'b0),
      .cand  (wr_cand),
      .gnt   (wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk   (clk),
      .reset (reset),
      .req   (rd_req),
      .hold  (rd_hold),
      .cand  (rd_cand),
      .gnt   (rd_gnt)
   );

   assign wr_addr_sel = wr_cand[1] ? wr_addr1 : wr_addr0;
   assign wr_data_sel = wr_cand[1] ? wr_data1 : wr_data0;
   assign rd_addr_sel = rd_cand[1] ? rd_addr1 : rd_addr0;
   assign ram_oce     = 1'b1;

   // Same-cycle write and read winners aimed at one address
   always_comb begin
      collision = (|wr_cand) && (|rd_cand) && (wr_addr_sel == rd_addr_sel);
   end

`ifdef SDPB_ARB_FORWARD_EN
   assign rd_hold = 1'b0;
   assign fwd_now = collision;
`else
   assign rd_hold = collision;
   assign fwd_now = 1'b0;
`endif

   // Register RAM commands; addresses and data hold when a port is idle
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_cea <= 1'b0;
         ram_ada <= '0;
         ram_din <= '0;
         ram_ceb <= 1'b0;
         ram_adb <= '0;
      end else begin
         ram_cea <= |wr_gnt;
         ram_ceb <= |rd_gnt;
         if (|wr_gnt) begin
            ram_ada <= wr_addr_sel;
            ram_din <= wr_data_sel;
         end
         if (|rd_gnt) begin
            ram_adb <= rd_addr_sel;
         end
      end
   end

   // Return pipeline: slot 0 lines up with ram_ceb, last slot with RAM data
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k <= READ_LAT; k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pipe[0].valid    <= |rd_gnt;
         pipe[0].id       <= rd_gnt[1];
         pipe[0].fwd      <= fwd_now & (|rd_gnt);
         pipe[0].fwd_data <= DATA_W_DEF'(wr_data_sel);
         for (int k = 1; k <= READ_LAT; k++) begin
            pipe[k] <= pipe[k-1];
         end
      end
   end

   // Steer returning data and the valid strobe to the requester that asked
   always_comb begin
      rd_valid = '0;
      rd_data  = '0;
      if (pipe[READ_LAT].valid) begin
         rd_valid[pipe[READ_LAT].id] = 1'b1;
         rd_data = pipe[READ_LAT].fwd ? DATA_W'(pipe[READ_LAT].fwd_data) : ram_dout;
      end
   end

endmodule
